// File: rtl/game_round_pkg.sv
// Shared definitions for the shooting-game round sequencer.
// Holds the FSM state encoding, the shot-counter width, the default
// debounce window and two small helpers for the armed-flag scheme.
package game_round_pkg;

    // Seven sequencer states packed into three bits. Kept as plain constants
    // so the encoding stays visible in waveforms and netlists.
    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE      = 3'd0;
    localparam state_t ST_LAUNCH_T  = 3'd1;
    localparam state_t ST_WAIT_FIRE = 3'd2;
    localparam state_t ST_LAUNCH_P  = 3'd3;
    localparam state_t ST_FLIGHT    = 3'd4;
    localparam state_t ST_RESOLVE   = 3'd5;
    localparam state_t ST_END_WAIT  = 3'd6;

    // Width of the torpedo counter, wide enough for up to 15 shots.
    localparam int SHOT_WIDTH = 4;

    // Default debounce counter width when debounce is compiled in.
    localparam int DEBOUNCE_WIDTH_DEFAULT = 16;

    // An armed input produces its "gone" event once it reads 0 again.
    function automatic logic armed_event(input logic armed, input logic level);
        return armed & ~level;
    endfunction

    // Next value of an armed flag: a launch or start disarms it, otherwise
    // the first sighting of the input at 1 arms it and it then stays armed.
    function automatic logic armed_next(input logic armed, input logic level,
                                        input logic clear);
        logic result;
        if (clear) begin
            result = 1'b0;
        end else begin
            result = armed | level;
        end
        return result;
    endfunction

endpackage

// File: rtl/game_key_edge.sv
// Fire/start key conditioning for the round sequencer.
// Synchronizes the asynchronous key into the clk domain and produces a
// one-cycle key_pulse on each accepted rising edge.
// Optional feature: GAME_ROUND_KEY_DEBOUNCE_EN adds a stability window of
// 2**DEBOUNCE_WIDTH cycles before a new key level is accepted.
module game_key_edge
    import game_round_pkg::*;
`ifdef GAME_ROUND_KEY_DEBOUNCE_EN
#(
    parameter int DEBOUNCE_WIDTH = DEBOUNCE_WIDTH_DEFAULT
)
`endif
(
    input  logic clk,
    input  logic reset,
    input  logic key,
    output logic key_pulse
);

    logic key_meta;
    logic key_sync;

    // Two-flop synchronizer bringing the raw button into the clk domain.
    always_ff @(posedge clk) begin
        if (reset) begin
            key_meta <= 1'b0;
            key_sync <= 1'b0;
        end else begin
            key_meta <= key;
            key_sync <= key_meta;
        end
    end

`ifdef GAME_ROUND_KEY_DEBOUNCE_EN

    logic [DEBOUNCE_WIDTH-1:0] stable_count;
    logic                      key_stable;

    // Accept a new level only after it has differed from the accepted level
    // for a full window; any bounce back restarts the window. The pulse is
    // raised on the cycle a new high level is accepted.
    always_ff @(posedge clk) begin
        if (reset) begin
            stable_count <= '0;
            key_stable   <= 1'b0;
            key_pulse    <= 1'b0;
        end else begin
            key_pulse <= 1'b0;
            if (key_sync == key_stable) begin
                stable_count <= '0;
            end else if (&stable_count) begin
                key_stable   <= key_sync;
                stable_count <= '0;
                key_pulse    <= key_sync;
            end else begin
                stable_count <= stable_count + DEBOUNCE_WIDTH'(1);
            end
        end
    end

`else

    logic key_prev;

    // Registered rising-edge detector on the synchronized key.
    always_ff @(posedge clk) begin
        if (reset) begin
            key_prev  <= 1'b0;
            key_pulse <= 1'b0;
        end else begin
            key_prev  <= key_sync;
            key_pulse <= key_sync & ~key_prev;
        end
    end

`endif

endmodule

// File: rtl/game_round_ctrl.sv
// Round sequencer for the shooting game.
// Launches target and torpedo sprites, counts shots and hits, decides win or
// loss and kicks off the end-of-game timer. Every output is registered and
// every strobe is a single-cycle pulse.
// Optional feature: GAME_ROUND_KEY_DEBOUNCE_EN enables key debouncing in the
// game_key_edge sub-module; without it the key is only synchronized.
module game_round_ctrl
    import game_round_pkg::*;
#(
    parameter int SHOTS_PER_ROUND = 4,
    parameter int HITS_TO_WIN     = 3,
    parameter int SCORE_WIDTH     = 4,
    parameter int DEBOUNCE_WIDTH  = DEBOUNCE_WIDTH_DEFAULT
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   key,
    input  logic                   target_within_screen,
    input  logic                   torpedo_within_screen,
    input  logic                   collision,
    input  logic                   end_of_game_timer_running,
    output logic                   sprite_target_write,
    output logic                   sprite_torpedo_write,
    output logic                   end_of_game_timer_start,
    output logic                   game_won,
    output logic                   round_active,
    output logic [SCORE_WIDTH-1:0] score,
    output logic [SHOT_WIDTH-1:0]  shots_left
);

    localparam logic [SHOT_WIDTH-1:0]  SHOTS_INIT  = SHOT_WIDTH'(SHOTS_PER_ROUND);
    localparam logic [SCORE_WIDTH-1:0] SCORE_MAX   = '1;
    localparam logic [SCORE_WIDTH:0]   HITS_NEEDED = (SCORE_WIDTH + 1)'(HITS_TO_WIN);

    logic   key_pulse;

    state_t state;
    state_t state_next;

    logic   armed_target;
    logic   armed_torpedo;
    logic   armed_timer;

    logic   target_gone;
    logic   torpedo_gone;
    logic   timer_done;

    logic   last_hit;
    logic   score_reached;

    logic   target_write_next;
    logic   torpedo_write_next;
    logic   timer_start_next;
    logic   game_start;
    logic   shot_fired;
    logic   hit_now;
    logic   resolve_enter;
    logic   resolve_win;

`ifdef GAME_ROUND_KEY_DEBOUNCE_EN
    game_key_edge #(
        .DEBOUNCE_WIDTH (DEBOUNCE_WIDTH)
    ) u_key_edge (
        .clk       (clk),
        .reset     (reset),
        .key       (key),
        .key_pulse (key_pulse)
    );
`else
    game_key_edge u_key_edge (
        .clk       (clk),
        .reset     (reset),
        .key       (key),
        .key_pulse (key_pulse)
    );

    // Debounce is compiled out; the width is still referenced so both builds
    // accept the same parameter list without a dangling parameter.
    if (DEBOUNCE_WIDTH < 1) begin : g_debounce_width_unused
    end
`endif

    assign target_gone   = armed_event(armed_target,  target_within_screen);
    assign torpedo_gone  = armed_event(armed_torpedo, torpedo_within_screen);
    assign timer_done    = armed_event(armed_timer,   end_of_game_timer_running);
    assign score_reached = ({1'b0, score} >= HITS_NEEDED);

    // Next-state and strobe decisions. Strobes are decided on the transition
    // into the launch states so they appear registered in the same cycle the
    // FSM enters LAUNCH_T / LAUNCH_P / END_WAIT.
    always_comb begin
        state_next         = state;
        target_write_next  = 1'b0;
        torpedo_write_next = 1'b0;
        timer_start_next   = 1'b0;
        game_start         = 1'b0;
        shot_fired         = 1'b0;
        hit_now            = 1'b0;
        resolve_enter      = 1'b0;
        resolve_win        = 1'b0;

        case (state)
            ST_IDLE: begin
                if (key_pulse) begin
                    state_next        = ST_LAUNCH_T;
                    target_write_next = 1'b1;
                    game_start        = 1'b1;
                end
            end

            ST_LAUNCH_T: begin
                state_next = ST_WAIT_FIRE;
            end

            ST_WAIT_FIRE: begin
                if (target_gone) begin
                    state_next        = ST_LAUNCH_T;
                    target_write_next = 1'b1;
                end else if (key_pulse) begin
                    state_next         = ST_LAUNCH_P;
                    torpedo_write_next = 1'b1;
                    shot_fired         = 1'b1;
                end
            end

            ST_LAUNCH_P: begin
                state_next = ST_FLIGHT;
            end

            ST_FLIGHT: begin
                if (target_gone) begin
                    target_write_next = 1'b1;
                end
                if (collision) begin
                    hit_now       = 1'b1;
                    resolve_enter = 1'b1;
                    state_next    = ST_RESOLVE;
                end else if (torpedo_gone) begin
                    resolve_enter = 1'b1;
                    state_next    = ST_RESOLVE;
                end
            end

            ST_RESOLVE: begin
                if (score_reached) begin
                    state_next       = ST_END_WAIT;
                    timer_start_next = 1'b1;
                    resolve_win      = 1'b1;
                end else if (shots_left == '0) begin
                    state_next       = ST_END_WAIT;
                    timer_start_next = 1'b1;
                end else if (last_hit) begin
                    state_next        = ST_LAUNCH_T;
                    target_write_next = 1'b1;
                end else begin
                    state_next = ST_WAIT_FIRE;
                end
            end

            ST_END_WAIT: begin
                if (timer_done) begin
                    state_next = ST_IDLE;
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // State register and the three single-cycle strobes.
    always_ff @(posedge clk) begin
        if (reset) begin
            state                   <= ST_IDLE;
            sprite_target_write     <= 1'b0;
            sprite_torpedo_write    <= 1'b0;
            end_of_game_timer_start <= 1'b0;
        end else begin
            state                   <= state_next;
            sprite_target_write     <= target_write_next;
            sprite_torpedo_write    <= torpedo_write_next;
            end_of_game_timer_start <= timer_start_next;
        end
    end

    // Armed flags: disarmed by the strobe that relaunches or restarts the
    // source, armed on the first sighting of the input high.
    always_ff @(posedge clk) begin
        if (reset) begin
            armed_target  <= 1'b0;
            armed_torpedo <= 1'b0;
            armed_timer   <= 1'b0;
        end else begin
            armed_target  <= armed_next(armed_target, target_within_screen,
                                        target_write_next);
            armed_torpedo <= armed_next(armed_torpedo, torpedo_within_screen,
                                        torpedo_write_next);
            armed_timer   <= armed_next(armed_timer, end_of_game_timer_running,
                                        timer_start_next);
        end
    end

    // Shot and score counters. A new game reloads both; the score saturates
    // rather than wrapping so a narrow counter never falls below the target.
    always_ff @(posedge clk) begin
        if (reset) begin
            score      <= '0;
            shots_left <= SHOTS_INIT;
        end else if (game_start) begin
            score      <= '0;
            shots_left <= SHOTS_INIT;
        end else begin
            if (shot_fired && (shots_left != '0)) begin
                shots_left <= shots_left - SHOT_WIDTH'(1);
            end
            if (hit_now && (score != SCORE_MAX)) begin
                score <= score + SCORE_WIDTH'(1);
            end
        end
    end

    // Remembers whether the shot being resolved was a hit, which decides
    // between a fresh target and another attempt at the current one.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_hit <= 1'b0;
        end else if (resolve_enter) begin
            last_hit <= hit_now;
        end
    end

    // Game result and activity flag. The result is held until the next game
    // starts; the round stops being active when the end timer is started.
    always_ff @(posedge clk) begin
        if (reset) begin
            game_won     <= 1'b0;
            round_active <= 1'b0;
        end else if (game_start) begin
            game_won     <= 1'b0;
            round_active <= 1'b1;
        end else if (timer_start_next) begin
            game_won     <= resolve_win;
            round_active <= 1'b0;
        end
    end

endmodule

// File: tb/tb_game_round_ctrl.sv
// Self-checking bench for game_round_ctrl.
// Stimulus pushes the expected outcome of each action into a scoreboard
// queue; a monitor pops and compares whenever the DUT raises a strobe or a
// state snapshot is requested. Builds with or without
// GAME_ROUND_KEY_DEBOUNCE_EN (debounce width fixed at 4).
module tb_game_round_ctrl;

    localparam int DBW = 4;
`ifdef GAME_ROUND_KEY_DEBOUNCE_EN
    localparam int KEY_LAT = 19;
    localparam int HOLD    = 20;
    localparam int SETTLE  = 40;
`else
    localparam int KEY_LAT = 4;
    localparam int HOLD    = 2;
    localparam int SETTLE  = 8;
`endif

    localparam int K_TGT   = 0;
    localparam int K_TORP  = 1;
    localparam int K_TIMER = 2;
    localparam int K_SNAP  = 3;
    localparam int K_NONE  = -1;

    typedef struct {
        int kind;
        int cyc;
        int score;
        int shots;
        int won;
        int active;
    } exp_t;

    logic       clk;
    logic       reset;
    logic       key;
    logic       target_within_screen;
    logic       torpedo_within_screen;
    logic       collision;
    logic       end_of_game_timer_running;
    logic       sprite_target_write;
    logic       sprite_torpedo_write;
    logic       end_of_game_timer_start;
    logic       game_won;
    logic       round_active;
    logic [3:0] score;
    logic [3:0] shots_left;

    exp_t sbq[$];
    int   cyc       = 0;
    int   checks    = 0;
    int   passed    = 0;
    int   snap_reqs = 0;
    int   snap_done = 0;

    game_round_ctrl #(
        .SHOTS_PER_ROUND (4),
        .HITS_TO_WIN     (3),
        .SCORE_WIDTH     (4),
        .DEBOUNCE_WIDTH  (DBW)
    ) dut (
        .clk                       (clk),
        .reset                     (reset),
        .key                       (key),
        .target_within_screen      (target_within_screen),
        .torpedo_within_screen     (torpedo_within_screen),
        .collision                 (collision),
        .end_of_game_timer_running (end_of_game_timer_running),
        .sprite_target_write       (sprite_target_write),
        .sprite_torpedo_write      (sprite_torpedo_write),
        .end_of_game_timer_start   (end_of_game_timer_start),
        .game_won                  (game_won),
        .round_active              (round_active),
        .score                     (score),
        .shots_left                (shots_left)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Counts active edges so expectations can name the cycle they land in.
    always @(posedge clk) begin
        cyc <= cyc + 1;
    end

    function automatic string kindName(input int k);
        case (k)
            K_TGT:   return "target_write";
            K_TORP:  return "torpedo_write";
            K_TIMER: return "timer_start";
            K_SNAP:  return "snapshot";
            default: return "none";
        endcase
    endfunction

    // Pops the oldest expectation and compares it with what the DUT shows.
    task automatic checkOutput(input int kind);
        exp_t e;
        bit   ok;
        checks++;
        if (sbq.size() == 0) begin
            $display("[TB] FAIL unexpected_%s at cycle %0d: got strobe/snapshot, required nothing pending",
                     kindName(kind), cyc);
            return;
        end
        e  = sbq.pop_front();
        ok = (e.kind == kind) && (e.cyc < 0 || e.cyc == cyc) &&
             (int'(score) == e.score) && (int'(shots_left) == e.shots) &&
             (int'(game_won) == e.won) && (int'(round_active) == e.active);
        if (ok) begin
            passed++;
        end else begin
            $display("[TB] FAIL %s: got kind=%s cyc=%0d score=%0d shots=%0d won=%0d active=%0d, required kind=%s cyc=%0d score=%0d shots=%0d won=%0d active=%0d",
                     kindName(e.kind), kindName(kind), cyc, score, shots_left, game_won,
                     round_active, kindName(e.kind), e.cyc, e.score, e.shots, e.won, e.active);
        end
    endtask

    // Monitor: samples just after each active edge.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (sprite_target_write)     checkOutput(K_TGT);
            if (sprite_torpedo_write)    checkOutput(K_TORP);
            if (end_of_game_timer_start) checkOutput(K_TIMER);
            if (snap_reqs != snap_done) begin
                checkOutput(K_SNAP);
                snap_done = snap_reqs;
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got no end of test, required finish before 2 ms");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_item(input int kind, input int at, input int sc,
                               input int sh, input int w, input int a);
        exp_t e;
        e = '{kind, at, sc, sh, w, a};
        sbq.push_back(e);
    endtask

    task automatic applyStimulus(input logic k, input logic tgt, input logic torp,
                                 input logic coll, input logic tmr);
        key                       = k;
        target_within_screen      = tgt;
        torpedo_within_screen     = torp;
        collision                 = coll;
        end_of_game_timer_running = tmr;
    endtask

    task automatic snapshot(input int sc, input int sh, input int w, input int a);
        expect_item(K_SNAP, -1, sc, sh, w, a);
        snap_reqs++;
        tick(2);
    endtask

    task automatic pressKey(input int kind, input int sc, input int sh,
                            input int w, input int a, input int hold);
        if (kind != K_NONE) expect_item(kind, cyc + KEY_LAT, sc, sh, w, a);
        key = 1'b1;
        tick(hold);
        key = 1'b0;
        tick(SETTLE);
    endtask

    task automatic hit(input bit also_exit, input int kind, input int sc,
                       input int sh, input int w, input int a);
        torpedo_within_screen = 1'b1;
        tick(2);
        collision = 1'b1;
        if (also_exit) torpedo_within_screen = 1'b0;
        expect_item(kind, cyc + 2, sc, sh, w, a);
        tick(1);
        collision             = 1'b0;
        torpedo_within_screen = 1'b0;
        tick(SETTLE);
    endtask

    task automatic miss(input int kind, input int sc, input int sh,
                        input int w, input int a);
        torpedo_within_screen = 1'b1;
        tick(2);
        torpedo_within_screen = 1'b0;
        if (kind != K_NONE) expect_item(kind, cyc + 2, sc, sh, w, a);
        tick(SETTLE);
    endtask

    task automatic timerRun(input int n);
        tick(2);
        end_of_game_timer_running = 1'b1;
        tick(n);
        end_of_game_timer_running = 1'b0;
        tick(3);
    endtask

    initial begin
        reset = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(3);
        snapshot(0, 4, 0, 0);
        reset = 1'b0;
        tick(2);

        $display("[TB] game 1: relaunch then three hits");
        pressKey(K_TGT, 0, 4, 0, 1, HOLD);
        target_within_screen = 1'b1;
        tick(3);
        target_within_screen = 1'b0;
        expect_item(K_TGT, cyc + 1, 0, 4, 0, 1);
        tick(3);
        target_within_screen = 1'b1;
        tick(3);
        pressKey(K_TORP, 0, 3, 0, 1, HOLD);
        hit(1'b0, K_TGT, 1, 3, 0, 1);
        pressKey(K_TORP, 1, 2, 0, 1, HOLD);
        hit(1'b0, K_TGT, 2, 2, 0, 1);
        pressKey(K_TORP, 2, 1, 0, 1, HOLD);
        hit(1'b1, K_TIMER, 3, 1, 1, 0);
        pressKey(K_NONE, 0, 0, 0, 0, HOLD);
        snapshot(3, 1, 1, 0);
        timerRun(10);

        $display("[TB] game 2: four misses");
        pressKey(K_TGT, 0, 4, 0, 1, HOLD);
        pressKey(K_TORP, 0, 3, 0, 1, HOLD);
        torpedo_within_screen = 1'b1;
        tick(2);
        target_within_screen = 1'b0;
        expect_item(K_TGT, cyc + 1, 0, 3, 0, 1);
        tick(2);
        target_within_screen = 1'b1;
        tick(2);
        torpedo_within_screen = 1'b0;
        tick(SETTLE);
        pressKey(K_TORP, 0, 2, 0, 1, 100);
        miss(K_NONE, 0, 0, 0, 0);
`ifdef GAME_ROUND_KEY_DEBOUNCE_EN
        key = 1'b1;
        tick(10);
        key = 1'b0;
        tick(SETTLE);
`endif
        pressKey(K_TORP, 0, 1, 0, 1, HOLD);
        miss(K_NONE, 0, 0, 0, 0);
        pressKey(K_TORP, 0, 0, 0, 1, HOLD);
        miss(K_TIMER, 0, 0, 0, 0);
        timerRun(10);
        snapshot(0, 0, 0, 0);

        $display("[TB] game 3: reset during flight");
        pressKey(K_TGT, 0, 4, 0, 1, HOLD);
        pressKey(K_TORP, 0, 3, 0, 1, HOLD);
        torpedo_within_screen = 1'b1;
        tick(2);
        reset = 1'b1;
        tick(2);
        snapshot(0, 4, 0, 0);
        reset = 1'b0;
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        tick(10);

        checks++;
        if (sbq.size() == 0) begin
            passed++;
        end else begin
            $display("[TB] FAIL pending_expectations: got %0d still queued, required 0 (next kind=%s cyc=%0d)",
                     sbq.size(), kindName(sbq[0].kind), sbq[0].cyc);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
